// File: rtl/dp_sequencer.sv
// Datapath command sequencer: expands LOAD/ALU/STORE block commands into
// per-element two-cycle (ISSUE, WAIT) datapath control words.
module dp_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [3:0]            cmd_alu_op,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  input  logic [IDX_WIDTH-1:0]  cmd_base,
  input  logic [IDX_WIDTH:0]    cmd_count,
  input  logic                  abort,
  output logic                  X,
  output logic                  Y,
  output logic                  R_W,
  output logic [IDX_WIDTH-1:0]  W_INST,
  output logic [IDX_WIDTH-1:0]  R_INST,
  output logic [IDX_WIDTH-1:0]  ADDR,
  output logic [21:0]           OSD,
  output logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] B_imm,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_ALU   = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  localparam logic [IDX_WIDTH:0] MAX_COUNT = {1'b1, {IDX_WIDTH{1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [3:0]            aluOp_q, aluOp_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [IDX_WIDTH-1:0]  base_q, base_d;
  logic [IDX_WIDTH:0]    count_q, count_d;
  logic [IDX_WIDTH:0]    i_q, i_d;
  logic [IDX_WIDTH:0]    iInc;
  logic                  cmdLegal;
  logic                  errNext;

  logic                  cmdReady_q, cmdReady_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  x_q, x_d;
  logic                  y_q, y_d;
  logic                  rw_q, rw_d;
  logic [IDX_WIDTH-1:0]  wInst_q, wInst_d;
  logic [IDX_WIDTH-1:0]  rInst_q, rInst_d;
  logic [IDX_WIDTH-1:0]  addr_q, addr_d;
  logic [21:0]           osd_q, osd_d;
  logic [1:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] bImm_q, bImm_d;
  logic [IDX_WIDTH-1:0]  idx_d;
  logic [5:0]            osdIdx;

  assign iInc     = i_q + 1'b1;
  assign cmdLegal = (cmd_op != 2'd3) && (cmd_count != '0) && (cmd_count <= MAX_COUNT);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    aluOp_d = aluOp_q;
    imm_d   = imm_q;
    base_d  = base_q;
    count_d = count_q;
    i_d     = i_q;
    errNext = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmdReady_q) begin
          op_d    = cmd_op;
          aluOp_d = cmd_alu_op;
          imm_d   = cmd_imm;
          base_d  = cmd_base;
          count_d = cmd_count;
          i_d     = '0;
          if (cmdLegal) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_FIN;
            errNext = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_FIN;
          errNext = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_FIN;
          errNext = 1'b1;
        end else begin
          i_d     = iInc;
          state_d = (iInc == count_q) ? S_FIN : S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered controls line
  // up with the state they belong to, with no input-to-output path.
  assign idx_d  = base_d + i_d[IDX_WIDTH-1:0];
  assign osdIdx = 6'(idx_d);

  always_comb begin
    cmdReady_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    err_d      = errNext;
    x_d        = 1'b0;
    y_d        = 1'b0;
    rw_d       = 1'b0;
    wInst_d    = '0;
    rInst_d    = '0;
    addr_d     = '0;
    osd_d      = '0;
    sel_d      = 2'd0;
    bImm_d     = '0;
    if ((state_d == S_ISSUE) || (state_d == S_WAIT)) begin
      case (op_d)
        OP_LOAD: begin
          x_d     = 1'b1;
          rw_d    = 1'b1;
          addr_d  = idx_d;
          wInst_d = idx_d;
        end
        OP_STORE: begin
          y_d     = 1'b1;
          addr_d  = idx_d;
          rInst_d = idx_d;
        end
        OP_ALU: begin
          sel_d         = 2'd1;
          bImm_d        = imm_d;
          osd_d[21:18]  = aluOp_d;
          osd_d[17:12]  = osdIdx;
          if (state_d == S_WAIT) begin
            osd_d[5:0] = osdIdx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      aluOp_q    <= '0;
      imm_q      <= '0;
      base_q     <= '0;
      count_q    <= '0;
      i_q        <= '0;
      cmdReady_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      x_q        <= 1'b0;
      y_q        <= 1'b0;
      rw_q       <= 1'b0;
      wInst_q    <= '0;
      rInst_q    <= '0;
      addr_q     <= '0;
      osd_q      <= '0;
      sel_q      <= '0;
      bImm_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      aluOp_q    <= aluOp_d;
      imm_q      <= imm_d;
      base_q     <= base_d;
      count_q    <= count_d;
      i_q        <= i_d;
      cmdReady_q <= cmdReady_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rw_q       <= rw_d;
      wInst_q    <= wInst_d;
      rInst_q    <= rInst_d;
      addr_q     <= addr_d;
      osd_q      <= osd_d;
      sel_q      <= sel_d;
      bImm_q     <= bImm_d;
    end
  end

  assign cmd_ready = cmdReady_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign X         = x_q;
  assign Y         = y_q;
  assign R_W       = rw_q;
  assign W_INST    = wInst_q;
  assign R_INST    = rInst_q;
  assign ADDR      = addr_q;
  assign OSD       = osd_q;
  assign sel       = sel_q;
  assign B_imm     = bImm_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Randomized bench for dp_sequencer: each command is expanded by a reference
// model into the expected per-cycle output trace and compared cycle by cycle.
module tb_dp_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_alu_op;
  logic [31:0] cmd_imm;
  logic [5:0]  cmd_base;
  logic [6:0]  cmd_count;
  logic        abort;
  logic        X, Y, R_W;
  logic [5:0]  W_INST, R_INST, ADDR;
  logic [21:0] OSD;
  logic [1:0]  sel;
  logic [31:0] B_imm;
  logic        busy, done, err;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic        x, y, rw;
    logic [1:0]  sel;
    logic [5:0]  wInst, rInst, addr;
    logic [21:0] osd;
    logic [31:0] bImm;
    logic        busy, done, err, ready;
  } rec_t;

  rec_t expQ[$];

  dp_sequencer #(.DATA_WIDTH(32), .IDX_WIDTH(6)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_alu_op(cmd_alu_op), .cmd_imm(cmd_imm),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .abort(abort),
    .X(X), .Y(Y), .R_W(R_W),
    .W_INST(W_INST), .R_INST(R_INST), .ADDR(ADDR),
    .OSD(OSD), .sel(sel), .B_imm(B_imm),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic rec_t idleRec(input logic ready);
    rec_t r;
    r = '{default: '0};
    r.ready = ready;
    return r;
  endfunction

  function automatic rec_t finRec(input logic e);
    rec_t r;
    r = '{default: '0};
    r.busy = 1'b1;
    r.done = 1'b1;
    r.err  = e;
    return r;
  endfunction

  // One element step of a command; isWait selects the second cycle of the pair.
  function automatic rec_t stepRec(input int op, input int aluOp, input logic [31:0] imm,
                                   input int idx, input bit isWait);
    rec_t r;
    r = '{default: '0};
    r.busy = 1'b1;
    if (op == 0) begin
      r.x = 1'b1; r.rw = 1'b1; r.addr = 6'(idx); r.wInst = 6'(idx);
    end else if (op == 2) begin
      r.y = 1'b1; r.addr = 6'(idx); r.rInst = 6'(idx);
    end else begin
      r.sel  = 2'd1;
      r.bImm = imm;
      r.osd  = {4'(aluOp), 6'(idx), 6'd0, (isWait ? 6'(idx) : 6'd0)};
    end
    return r;
  endfunction

  task automatic buildTrace(input int op, input int aluOp, input logic [31:0] imm,
                            input int base, input int count, input int abortAt);
    expQ.delete();
    if (op == 3 || count < 1 || count > 64) begin
      expQ.push_back(finRec(1'b1));
      return;
    end
    for (int s = 0; s < 2 * count; s++) begin
      expQ.push_back(stepRec(op, aluOp, imm, (base + s / 2) % 64, (s % 2) == 1));
      if (s == abortAt) begin
        expQ.push_back(finRec(1'b1));
        return;
      end
    end
    expQ.push_back(finRec(1'b0));
  endtask

  task automatic compareRec(input string tag, input rec_t e);
    checkOutput({tag, ".ctl"}, 64'({X, Y, R_W, sel, W_INST, R_INST, ADDR}),
                64'({e.x, e.y, e.rw, e.sel, e.wInst, e.rInst, e.addr}));
    checkOutput({tag, ".osd"}, 64'(OSD), 64'(e.osd));
    checkOutput({tag, ".bimm"}, 64'(B_imm), 64'(e.bImm));
    checkOutput({tag, ".stat"}, 64'({busy, done, err, cmd_ready}),
                64'({e.busy, e.done, e.err, e.ready}));
  endtask

  task automatic driveCmd(input int op, input int aluOp, input logic [31:0] imm,
                          input int base, input int count);
    cmd_valid  = 1'b1;
    cmd_op     = 2'(op);
    cmd_alu_op = 4'(aluOp);
    cmd_imm    = imm;
    cmd_base   = 6'(base);
    cmd_count  = 7'(count);
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge of
  // the idle cycle following the done pulse. Noise drives unrelated commands
  // while busy, which must be ignored.
  task automatic applyStimulus(input string name, input int op, input int aluOp,
                               input logic [31:0] imm, input int base, input int count,
                               input int abortAt, input bit noise);
    buildTrace(op, aluOp, imm, base, count, abortAt);
    driveCmd(op, aluOp, imm, base, count);
    @(negedge CLK);
    cmd_valid = 1'b0;
    for (int j = 0; j < expQ.size(); j++) begin
      compareRec($sformatf("%s[%0d]", name, j), expQ[j]);
      abort = (j == abortAt);
      if (noise) begin
        driveCmd($urandom_range(0, 3), $urandom_range(0, 15), $urandom,
                 $urandom_range(0, 63), $urandom_range(0, 127));
        cmd_valid = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
    end
    abort = 1'b0;
    compareRec({name, ".idle"}, idleRec(1'b1));
    cmd_valid = 1'b0;
  endtask

  initial begin
    int op, cnt, base, aluOp, abortAt, c;
    logic [31:0] imm;
    nCompared   = 0;
    nMismatched = 0;
    RST_N      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_alu_op = '0;
    cmd_imm    = '0;
    cmd_base   = '0;
    cmd_count  = '0;
    abort      = 1'b0;
    #2 RST_N = 1'b0;
    cmd_valid = 1'b1;
    @(negedge CLK);
    compareRec("reset0", idleRec(1'b0));
    @(negedge CLK);
    compareRec("reset1", idleRec(1'b0));
    cmd_valid = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
    compareRec("released", idleRec(1'b1));

    applyStimulus("load64", 0, 0, 32'd0, 0, 64, -1, 1'b0);
    applyStimulus("alu3", 1, 0, 32'd43, 5, 3, -1, 1'b0);
    applyStimulus("store4", 2, 0, 32'd0, 62, 4, -1, 1'b1);
    applyStimulus("badop", 3, 2, 32'd7, 10, 5, -1, 1'b0);
    applyStimulus("cnt0", 0, 0, 32'd0, 3, 0, -1, 1'b0);
    applyStimulus("cnt100", 2, 0, 32'd0, 3, 100, -1, 1'b0);
    applyStimulus("abortW2", 0, 0, 32'd0, 20, 10, 5, 1'b0);
    applyStimulus("store64", 2, 0, 32'd0, 33, 64, -1, 1'b1);

    // Reset in the issue cycle of element 1 of an ALU command.
    buildTrace(1, 9, 32'hDEAD_BEEF, 40, 6, -1);
    driveCmd(1, 9, 32'hDEAD_BEEF, 40, 6);
    @(negedge CLK);
    cmd_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      compareRec($sformatf("preRst[%0d]", j), expQ[j]);
      if (j < 2) @(negedge CLK);
    end
    RST_N = 1'b0;
    #1;
    compareRec("midRst", idleRec(1'b0));
    @(negedge CLK);
    compareRec("midRstHold", idleRec(1'b0));
    RST_N = 1'b1;
    @(negedge CLK);
    compareRec("postRst", idleRec(1'b1));
    applyStimulus("storeAfterRst", 2, 0, 32'd0, 60, 7, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op    = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      c     = $urandom_range(0, 19);
      cnt   = (c == 0) ? 0 : (c == 1) ? $urandom_range(65, 127) : (c == 2) ? 64 : $urandom_range(1, 20);
      base  = $urandom_range(0, 63);
      aluOp = $urandom_range(0, 15);
      imm   = $urandom;
      abortAt = -1;
      if (op != 3 && cnt >= 1 && cnt <= 64) begin
        if ($urandom_range(0, 3) == 0) abortAt = $urandom_range(0, 2 * cnt - 1);
      end else if ($urandom_range(0, 1) == 1) begin
        abortAt = 0;
      end
      applyStimulus($sformatf("rnd%0d", n), op, aluOp, imm, base, cnt, abortAt, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
